// File: rtl/hack_rom_loader.sv
// Hack ROM loader: parses a LEN/words/CSUM byte frame, writes words into instruction ROM,
// and releases the CPU from reset only after the frame's checksum matches.
module hack_rom_loader #(
  parameter int ROM_DEPTH = 32768,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded,
  output logic [2:0]        fsm_state
);

  // Handshake: a byte moves on any rising edge where in_valid & in_ready are both high;
  // in_ready depends only on state, and in_valid low for any number of cycles is harmless.

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_RUN, S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [15:0]       len_q;
  logic [7:0]        hi_q;
  logic [7:0]        csum;
  logic              xfer;
  logic              start;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   cnt_plus;

  assign xfer     = in_valid & in_ready;
  assign start    = load_start & ((state == S_IDLE) | (state == S_RUN) | (state == S_ERROR));
  assign len_full = {len_q[15:8], in_data};
  assign cnt_plus = {1'b0, words_loaded} + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_RUN, S_ERROR: if (load_start) state_next = S_LEN_HI;
      S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
      S_LEN_LO:
        if (xfer) begin
          if (32'(len_full) == 32'd0 || 32'(len_full) > 32'(ROM_DEPTH)) state_next = S_ERROR;
          else                                                          state_next = S_DATA_HI;
        end
      S_DATA_HI: if (xfer) state_next = S_DATA_LO;
      S_DATA_LO:
        if (xfer) state_next = (32'(cnt_plus) == 32'(len_q)) ? S_CSUM : S_DATA_HI;
      S_CSUM:    if (xfer) state_next = (in_data == csum) ? S_RUN : S_ERROR;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_LEN_HI) | (state == S_LEN_LO) | (state == S_DATA_HI) |
                (state == S_DATA_LO) | (state == S_CSUM);
    cpu_reset = (state != S_RUN);
    done      = (state == S_RUN);
    error     = (state == S_ERROR);
    fsm_state = state;
  end

  // Datapath; the ROM write is registered so it lands in the cycle after the lo byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q        <= '0;
      hi_q         <= '0;
      csum         <= '0;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      rom_we <= 1'b0;
      if (start) begin
        words_loaded <= '0;
        csum         <= '0;
      end
      if (xfer) begin
        case (state)
          S_LEN_HI:  len_q[15:8] <= in_data;
          S_LEN_LO:  len_q[7:0]  <= in_data;
          S_DATA_HI: begin
            hi_q <= in_data;
            csum <= csum + in_data;
          end
          S_DATA_LO: begin
            csum         <= csum + in_data;
            rom_we       <= 1'b1;
            rom_wdata    <= {hi_q, in_data};
            rom_addr     <= words_loaded;
            words_loaded <= words_loaded + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
